// File: rtl/rho_pi_slice_permute_if.sv
// ---------------------------------------------------------------------------
// rho_pi_slice_permute_if : slice stream in, permuted slice/write strobe out
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface rho_pi_slice_permute_if #(
  parameter int INDEX_W = 10
);
  logic               in_valid;
  logic               in_ready;
  logic [24:0]        data_in;
  logic               write_file;
  logic [INDEX_W-1:0] file_index;
  logic [24:0]        data_out;
  logic               busy;

  modport master (
    output in_valid, data_in,
    input  in_ready, write_file, file_index, data_out, busy
  );

  modport slave (
    input  in_valid, data_in,
    output in_ready, write_file, file_index, data_out, busy
  );
endinterface

`default_nettype wire

// File: rtl/rho_pi_slice_permute.sv
// ---------------------------------------------------------------------------
// rho_pi_slice_permute : gathers 64 serial 25-bit slices, emits rho+pi result
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module rho_pi_slice_permute #(
  parameter int          INDEX_W     = 10,
  parameter int unsigned START_INDEX = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  rho_pi_slice_permute_if.slave   bus
);

  typedef enum logic [0:0] {
    S_LOAD = 1'b0,
    S_EMIT = 1'b1
  } state_e;

  // Rho rotation per source lane, indexed by lane number x+5y.
  localparam logic [5:0] RHO [25] = '{
    6'd0,  6'd1,  6'd62, 6'd28, 6'd27,
    6'd36, 6'd44, 6'd6,  6'd55, 6'd20,
    6'd3,  6'd10, 6'd43, 6'd25, 6'd39,
    6'd41, 6'd45, 6'd15, 6'd21, 6'd8,
    6'd18, 6'd2,  6'd61, 6'd56, 6'd14
  };

  state_e                  state_q, state_d;
  logic [5:0]              load_cnt_q, load_cnt_d;
  logic [6:0]              emit_cnt_q, emit_cnt_d;
  logic                    write_file_q, write_file_d;
  logic [24:0]             data_out_q, data_out_d;
  logic [INDEX_W-1:0]      file_index_q, file_index_d;
  logic [24:0][63:0]       lane_q, lane_d;
  logic [24:0]             perm_slice;

  // Output lane (x,y) reads source lane (u,x), u=(x+3y) mod 5, rotated by rho.
  for (genvar i = 0; i < 25; i++) begin : g_perm
    localparam int X   = i % 5;
    localparam int Y   = i / 5;
    localparam int U   = (X + 3 * Y) % 5;
    localparam int SRC = U + 5 * X;
    logic [5:0] rd_idx;
    assign rd_idx        = emit_cnt_q[5:0] - RHO[SRC];
    assign perm_slice[i] = lane_q[SRC][rd_idx];
  end

  always_comb begin
    state_d      = state_q;
    load_cnt_d   = load_cnt_q;
    emit_cnt_d   = emit_cnt_q;
    write_file_d = 1'b0;
    data_out_d   = '0;
    file_index_d = file_index_q;
    lane_d       = lane_q;
    case (state_q)
      S_LOAD: begin
        if (bus.in_valid) begin
          for (int i = 0; i < 25; i++) begin
            lane_d[i][load_cnt_q] = bus.data_in[i];
          end
          load_cnt_d = load_cnt_q + 6'd1;
          if (load_cnt_q == 6'd63) begin
            state_d = S_EMIT;
          end
        end
      end
      S_EMIT: begin
        // Counter value 64 is the extra cycle that closes out the state.
        if (!emit_cnt_q[6]) begin
          write_file_d = 1'b1;
          data_out_d   = perm_slice;
          emit_cnt_d   = emit_cnt_q + 7'd1;
        end else begin
          emit_cnt_d   = '0;
          file_index_d = file_index_q + 1'b1;
          state_d      = S_LOAD;
        end
      end
      default: state_d = S_LOAD;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_LOAD;
      load_cnt_q   <= '0;
      emit_cnt_q   <= '0;
      write_file_q <= 1'b0;
      data_out_q   <= '0;
      file_index_q <= INDEX_W'(START_INDEX);
    end else begin
      state_q      <= state_d;
      load_cnt_q   <= load_cnt_d;
      emit_cnt_q   <= emit_cnt_d;
      write_file_q <= write_file_d;
      data_out_q   <= data_out_d;
      file_index_q <= file_index_d;
    end
  end

  // Lane storage is always fully rewritten before an emit, so it has no reset.
  always_ff @(posedge clk) begin
    lane_q <= lane_d;
  end

  assign bus.in_ready   = (state_q == S_LOAD);
  assign bus.busy       = (state_q == S_EMIT);
  assign bus.write_file = write_file_q;
  assign bus.data_out   = data_out_q;
  assign bus.file_index = file_index_q;

endmodule

`default_nettype wire
